// File: rtl/maxfind_stream_arbiter.sv
// Packet-granular round-robin arbiter that lets NUM_SRC AXI-Stream sources
// share a single max-finder datapath. A source keeps the grant from its first
// beat through the beat carrying TLAST; the arbiter itself stores no data.
module maxfind_stream_arbiter #(
  parameter int STREAM_WIDTH = 32,
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                            ACLK,
  input  logic                            ARESET_n,
  input  logic [NUM_SRC*STREAM_WIDTH-1:0] S_TDATA,
  input  logic [NUM_SRC-1:0]              S_TVALID,
  input  logic [NUM_SRC-1:0]              S_TLAST,
  output logic [NUM_SRC-1:0]              S_TREADY,
  output logic [STREAM_WIDTH-1:0]         M_TDATA,
  output logic                            M_TVALID,
  output logic                            M_TLAST,
  input  logic                            M_TREADY,
  output logic [SEL_W-1:0]                GRANT_ID,
  output logic                            BUSY,
  output logic                            PKT_DONE
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   grant_q;
  logic [SEL_W-1:0]   last_grant_q;
  logic               pkt_done_q;

  logic [SEL_W-1:0]   sel_d;
  logic               arb_found;
  logic [SEL_W-1:0]   cand_idx;
  int                 cand_pos;
  logic               xfer_last;

  // Round-robin pick: first requester found walking upward from the source
  // after the one that finished most recently, wrapping at NUM_SRC.
  always_comb begin
    sel_d     = '0;
    arb_found = 1'b0;
    cand_pos  = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_pos = (int'(last_grant_q) + k) % NUM_SRC;
      cand_idx = SEL_W'(cand_pos);
      if (!arb_found && S_TVALID[cand_idx]) begin
        sel_d     = cand_idx;
        arb_found = 1'b1;
      end
    end
  end

  // Pass-through of the granted source only; everything is quiet while idle.
  always_comb begin
    M_TDATA  = '0;
    M_TLAST  = 1'b0;
    M_TVALID = 1'b0;
    S_TREADY = '0;
    if (state_q == ST_BUSY) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == SEL_W'(i)) begin
          M_TDATA     = S_TDATA[i*STREAM_WIDTH +: STREAM_WIDTH];
          M_TLAST     = S_TLAST[i];
          M_TVALID    = S_TVALID[i];
          S_TREADY[i] = M_TREADY;
        end
      end
    end
  end

  assign xfer_last = (state_q == ST_BUSY) && M_TVALID && M_TREADY && M_TLAST;

  // Grant FSM: latch a winner in IDLE, release it after the TLAST handshake.
  always_ff @(posedge ACLK or negedge ARESET_n) begin
    if (!ARESET_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(NUM_SRC - 1);
      pkt_done_q   <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            grant_q <= sel_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (xfer_last) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
            pkt_done_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q == ST_BUSY);
  assign PKT_DONE = pkt_done_q;

endmodule

// File: tb/tb_maxfind_stream_arbiter.sv
// Bench for maxfind_stream_arbiter: bench-owned sources feed packets, a
// packet-level reference model predicts every output each cycle, and directed
// scenarios are followed by a randomized traffic phase.
module tb_maxfind_stream_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            ACLK = 1'b0;
  logic            ARESET_n;
  logic [N*W-1:0]  S_TDATA;
  logic [N-1:0]    S_TVALID;
  logic [N-1:0]    S_TLAST;
  logic [N-1:0]    S_TREADY;
  logic [W-1:0]    M_TDATA;
  logic            M_TVALID;
  logic            M_TLAST;
  logic            M_TREADY;
  logic [SW-1:0]   GRANT_ID;
  logic            BUSY;
  logic            PKT_DONE;

  maxfind_stream_arbiter #(.STREAM_WIDTH(W), .NUM_SRC(N), .SEL_W(SW)) dut (
    .ACLK(ACLK), .ARESET_n(ARESET_n),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .PKT_DONE(PKT_DONE)
  );

  // Free-running 10-unit clock.
  always #5 ACLK = ~ACLK;

  int nChecks = 0;
  int nErrors = 0;

  logic [W-1:0] srcMem  [N][64];
  bit           srcLast [N][64];
  int           head[N];
  int           tail[N];
  int           gap[N];
  int           gapNext[N];
  int           readyQ[$];
  bit           randomReady;
  bit           randomGaps;
  int           beatsLoaded;

  int           owner;
  int           mLast;
  int           mGrant;
  bit           mDone;

  int           obsOrder[$];
  int           doneCycles[$];
  logic [W-1:0] obsData[$];
  int           cycleNo;

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickNext(int last, logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic bit anyPending();
    bit p;
    p = (owner >= 0);
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic clearSources();
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; gap[i] = 0; gapNext[i] = 0;
    end
    readyQ.delete();
    obsOrder.delete();
    doneCycles.delete();
    obsData.delete();
    beatsLoaded = 0;
    randomReady = 1'b0;
    randomGaps  = 1'b0;
  endtask

  task automatic pushBeat(int src, logic [W-1:0] d, bit last);
    srcMem[src][tail[src]]  = d;
    srcLast[src][tail[src]] = last;
    tail[src]++;
    beatsLoaded++;
  endtask

  task automatic pushPacket(int src, int len, logic [W-1:0] base);
    for (int b = 0; b < len; b++) pushBeat(src, base + W'(b), b == len - 1);
  endtask

  task automatic applyStimulus();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    v = '0; d = '0; l = '0;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i] && gap[i] == 0) begin
        v[i]       = 1'b1;
        d[i*W +: W] = srcMem[i][head[i]];
        l[i]       = srcLast[i][head[i]];
      end
    end
    S_TVALID = v;
    S_TDATA  = d;
    S_TLAST  = l;
    if (readyQ.size() > 0) M_TREADY = (readyQ.pop_front() != 0);
    else if (randomReady)  M_TREADY = ($urandom_range(0, 3) != 0);
    else                   M_TREADY = 1'b1;
  endtask

  task automatic finishCycle();
    logic [N-1:0] eReady;
    logic [W-1:0] eData;
    bit           eBusy, eValid, eLast, hs;
    int           g;
    @(negedge ACLK);
    eBusy = (owner >= 0);
    eValid = 1'b0; eLast = 1'b0; eData = '0; eReady = '0;
    if (eBusy) begin
      eValid = S_TVALID[owner];
      eLast  = S_TLAST[owner];
      eData  = S_TDATA[owner*W +: W];
      eReady[owner] = M_TREADY;
    end
    checkOutput("BUSY", BUSY, eBusy);
    checkOutput("GRANT_ID", GRANT_ID, mGrant);
    checkOutput("M_TVALID", M_TVALID, eValid);
    checkOutput("M_TDATA", M_TDATA, eData);
    checkOutput("M_TLAST", M_TLAST, eLast);
    checkOutput("S_TREADY", S_TREADY, eReady);
    checkOutput("PKT_DONE", PKT_DONE, mDone);
    if (PKT_DONE === 1'b1) begin
      obsOrder.push_back(int'(GRANT_ID));
      doneCycles.push_back(cycleNo);
    end
    if (M_TVALID === 1'b1 && M_TREADY) obsData.push_back(M_TDATA);
    hs = eValid && M_TREADY;
    for (int i = 0; i < N; i++) begin
      if (eBusy && owner == i && hs) begin
        head[i]++;
        gap[i]     = gapNext[i];
        gapNext[i] = randomGaps ? int'($urandom_range(0, 2)) : 0;
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    if (eBusy) begin
      mDone = hs && eLast;
      if (hs && eLast) begin
        mLast = owner;
        owner = -1;
      end
    end else begin
      mDone = 1'b0;
      g = pickNext(mLast, S_TVALID);
      if (g >= 0) begin
        owner  = g;
        mGrant = g;
      end
    end
    cycleNo++;
    @(posedge ACLK);
    #1;
  endtask

  task automatic runCycles(int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      finishCycle();
    end
  endtask

  task automatic drain(int budget);
    int cnt;
    bit timedOut;
    cnt = 0;
    while (anyPending() && cnt < budget) begin
      runCycles(1);
      cnt++;
    end
    timedOut = anyPending();
    checkOutput("drainTimeout", timedOut, 1'b0);
    runCycles(2);
  endtask

  task automatic resetNow(bit checkImmediate);
    ARESET_n = 1'b0;
    #1;
    if (checkImmediate) begin
      checkOutput("rstM_TVALID", M_TVALID, 1'b0);
      checkOutput("rstS_TREADY", S_TREADY, '0);
      checkOutput("rstBUSY", BUSY, 1'b0);
      checkOutput("rstPKT_DONE", PKT_DONE, 1'b0);
      checkOutput("rstGRANT_ID", GRANT_ID, '0);
      checkOutput("rstM_TDATA", M_TDATA, '0);
      checkOutput("rstM_TLAST", M_TLAST, 1'b0);
    end
    owner = -1; mLast = N - 1; mGrant = 0; mDone = 1'b0;
    clearSources();
    S_TVALID = '0; S_TDATA = '0; S_TLAST = '0; M_TREADY = 1'b1;
    @(negedge ACLK);
    ARESET_n = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    ARESET_n = 1'b0;
    S_TVALID = '0; S_TDATA = '0; S_TLAST = '0; M_TREADY = 1'b0;
    cycleNo = 0;
    owner = -1; mLast = N - 1; mGrant = 0; mDone = 1'b0;
    clearSources();
    #3;
    resetNow(1'b1);

    // Single requester, three beats from source 2.
    $display("[TB] single requester");
    pushBeat(2, 32'h10, 1'b0);
    pushBeat(2, 32'h20, 1'b0);
    pushBeat(2, 32'h30, 1'b1);
    drain(50);
    checkOutput("t1DoneCount", obsOrder.size(), 1);
    checkOutput("t1Grant", obsOrder[0], 2);
    checkOutput("t1Beats", obsData.size(), 3);
    checkOutput("t1Data0", obsData[0], 32'h10);
    checkOutput("t1Data1", obsData[1], 32'h20);
    checkOutput("t1Data2", obsData[2], 32'h30);

    // Round robin with every source requesting continuously.
    $display("[TB] round robin");
    resetNow(1'b0);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) pushPacket(s, 2, W'(32'h100 * (s + 1) + 32'h10 * r));
    drain(100);
    checkOutput("t2DoneCount", obsOrder.size(), 8);
    for (int p = 0; p < 8; p++) checkOutput($sformatf("t2Order%0d", p), obsOrder[p], p % N);
    for (int p = 1; p < 8; p++)
      checkOutput($sformatf("t2Spacing%0d", p), doneCycles[p] - doneCycles[p-1], 3);

    // Backpressure on a four-beat packet from source 1.
    $display("[TB] backpressure");
    clearSources();
    readyQ = '{0, 1, 0, 0, 1, 1, 0, 1};
    pushPacket(1, 4, 32'hA0);
    drain(50);
    checkOutput("t3Beats", obsData.size(), 4);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("t3Data%0d", b), obsData[b], 32'hA0 + b);
    checkOutput("t3Grant", obsOrder[0], 1);

    // Source 0 pauses mid-packet while source 3 waits.
    $display("[TB] mid-packet bubble");
    clearSources();
    gapNext[0] = 3;
    pushPacket(0, 3, 32'hB0);
    runCycles(2);
    pushPacket(3, 1, 32'hC0);
    drain(50);
    checkOutput("t4DoneCount", obsOrder.size(), 2);
    checkOutput("t4First", obsOrder[0], 0);
    checkOutput("t4Second", obsOrder[1], 3);
    checkOutput("t4Data2", obsData[2], 32'hB2);
    checkOutput("t4Data3", obsData[3], 32'hC0);

    // Reset during beat 2 of a five-beat packet.
    $display("[TB] reset mid-packet");
    clearSources();
    pushPacket(1, 5, 32'hD0);
    runCycles(2);
    applyStimulus();
    resetNow(1'b1);
    pushPacket(1, 1, 32'hE1);
    pushPacket(2, 1, 32'hE2);
    drain(50);
    checkOutput("t5DoneCount", obsOrder.size(), 2);
    checkOutput("t5First", obsOrder[0], 1);
    checkOutput("t5Second", obsOrder[1], 2);

    // Single-beat packets from sources 0 and 3.
    $display("[TB] single-beat packets");
    resetNow(1'b0);
    pushBeat(0, 32'hFFFF, 1'b1);
    pushBeat(3, 32'h0001, 1'b1);
    drain(50);
    checkOutput("t6DoneCount", obsOrder.size(), 2);
    checkOutput("t6First", obsOrder[0], 0);
    checkOutput("t6Second", obsOrder[1], 3);
    checkOutput("t6Data0", obsData[0], 32'hFFFF);
    checkOutput("t6Data1", obsData[1], 32'h0001);
    checkOutput("t6Spacing", doneCycles[1] - doneCycles[0], 2);

    // Randomized traffic, gaps and backpressure.
    $display("[TB] random traffic");
    clearSources();
    randomReady = 1'b1;
    randomGaps  = 1'b1;
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 6; p++)
        pushPacket(s, int'($urandom_range(1, 5)), $urandom);
    drain(3000);
    checkOutput("randBeats", obsData.size(), beatsLoaded);
    checkOutput("randPackets", obsOrder.size(), N * 6);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
